// File: rtl/fx2_in_ep.sv
// ---------------------------------------------------------------------------
// fx2_in_ep
//
// FX2 IN (device->host) endpoint FIFO model. Device logic writes words over
// the FX2 slave-FIFO bus into one of NBUF packet buffers. A buffer is
// committed either automatically when PKT_WORDS words have been written or
// explicitly with pktend (short packet, or zero-length packet when empty).
// Committed packets are drained in order through the host-side port, one
// word (or one ZLP) per host_rd.
//
// Optional feature macro: FX2_IN_EP_PF_EN
//   defined     : pf is a registered occupancy flag, set when the committed
//                 but undrained words plus the words in the filling buffer
//                 reach PF_LEVEL.
//   not defined : pf is constant 0 and no occupancy arithmetic is built.
//
// Ports
//   ifclk       in   interface clock, all logic on the rising edge
//   reset_n     in   asynchronous active-low reset
//   fifoadr     in   FIFO address; this instance responds to FIFOADR only
//   data        in   write data
//   wr          in   write strobe
//   pktend      in   commit the packet being filled
//   full        out  every buffer committed and not yet drained
//   pf          out  programmable occupancy flag
//   ovf         out  sticky: write or pktend attempted while full
//   host_rd     in   host consumes one word (or one ZLP)
//   host_valid  out  at least one committed packet pending
//   host_data   out  current word of the head packet
//   host_len    out  length of the head packet in words (0 = ZLP)
//   host_last   out  current word/ZLP is the last of the head packet
// ---------------------------------------------------------------------------
module fx2_in_ep #(
    parameter logic [1:0] FIFOADR   = 2'b00,
    parameter int         DATA_W    = 8,
    parameter int         PKT_WORDS = 512,
    parameter int         NBUF      = 2,
    parameter int         PF_LEVEL  = 256,
    parameter int         LEN_W     = $clog2(PKT_WORDS + 1)
) (
    input  logic              ifclk,
    input  logic              reset_n,
    input  logic [1:0]        fifoadr,
    input  logic [DATA_W-1:0] data,
    input  logic              wr,
    input  logic              pktend,
    output logic              full,
    output logic              pf,
    output logic              ovf,
    input  logic              host_rd,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_data,
    output logic [LEN_W-1:0]  host_len,
    output logic              host_last
);

    localparam int BUF_W  = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int IDX_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int DEPTH  = NBUF * PKT_WORDS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(NBUF + 1);

    // Buffer pointer increment that wraps at NBUF (NBUF need not fill BUF_W).
    function automatic logic [BUF_W-1:0] buf_next(input logic [BUF_W-1:0] b);
        logic [BUF_W-1:0] n;
        if (b == BUF_W'(NBUF - 1)) begin
            n = '0;
        end else begin
            n = b + BUF_W'(1);
        end
        return n;
    endfunction

    // Flat storage address of word idx inside buffer b.
    function automatic logic [ADDR_W-1:0] mem_addr(input logic [BUF_W-1:0] b,
                                                   input logic [IDX_W-1:0] idx);
        return ADDR_W'(b) * ADDR_W'(PKT_WORDS) + ADDR_W'(idx);
    endfunction

    // State
    logic [BUF_W-1:0]  fill_buf_q,  fill_buf_d;
    logic [IDX_W-1:0]  fill_cnt_q,  fill_cnt_d;
    logic [BUF_W-1:0]  drain_buf_q, drain_buf_d;
    logic [IDX_W-1:0]  drain_idx_q, drain_idx_d;
    logic [CNT_W-1:0]  ncommit_q,   ncommit_d;
    logic [LEN_W-1:0]  len_q [NBUF];
    logic [LEN_W-1:0]  len_d [NBUF];
    logic              full_q,      full_d;
    logic              ovf_q,       ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Decoded events
    logic              sel_s;
    logic              wr_acc_s;
    logic              pe_acc_s;
    logic              auto_s;
    logic              commit_s;
    logic [LEN_W-1:0]  commit_len_s;
    logic              rd_acc_s;
    logic              release_s;

    // Bus decode: accept traffic only for our address and only while space remains.
    always_comb begin
        sel_s    = (fifoadr == FIFOADR);
        wr_acc_s = sel_s && wr && !full_q;
        pe_acc_s = sel_s && pktend && !full_q;
        // A write into the last slot commits by itself; a pktend in the same
        // cycle merges into that single commit instead of adding a ZLP.
        auto_s   = wr_acc_s && (fill_cnt_q == IDX_W'(PKT_WORDS - 1));
        commit_s = auto_s || pe_acc_s;
        if (auto_s) begin
            commit_len_s = LEN_W'(PKT_WORDS);
        end else if (wr_acc_s) begin
            commit_len_s = LEN_W'(fill_cnt_q) + LEN_W'(1);
        end else begin
            commit_len_s = LEN_W'(fill_cnt_q);
        end
    end

    // Host-side view of the head packet, derived from registered state.
    always_comb begin
        host_valid = (ncommit_q != '0);
        host_len   = len_q[drain_buf_q];
        host_data  = mem_q[mem_addr(drain_buf_q, drain_idx_q)];
        host_last  = host_valid &&
                     ((host_len == '0) || (LEN_W'(drain_idx_q) + LEN_W'(1) == host_len));
        rd_acc_s   = host_rd && host_valid;
        release_s  = rd_acc_s && host_last;
    end

    // Next-state computation for fill side, drain side and flags.
    always_comb begin
        fill_buf_d  = fill_buf_q;
        fill_cnt_d  = fill_cnt_q;
        drain_buf_d = drain_buf_q;
        drain_idx_d = drain_idx_q;
        ncommit_d   = ncommit_q;
        len_d       = len_q;

        if (commit_s) begin
            len_d[fill_buf_q] = commit_len_s;
            fill_buf_d        = buf_next(fill_buf_q);
            fill_cnt_d        = '0;
        end else if (wr_acc_s) begin
            fill_cnt_d = fill_cnt_q + IDX_W'(1);
        end else begin
            fill_cnt_d = fill_cnt_q;
        end

        if (release_s) begin
            drain_buf_d = buf_next(drain_buf_q);
            drain_idx_d = '0;
        end else if (rd_acc_s) begin
            drain_idx_d = drain_idx_q + IDX_W'(1);
        end else begin
            drain_idx_d = drain_idx_q;
        end

        // Simultaneous commit and release cancel out.
        case ({commit_s, release_s})
            2'b10:   ncommit_d = ncommit_q + CNT_W'(1);
            2'b01:   ncommit_d = ncommit_q - CNT_W'(1);
            default: ncommit_d = ncommit_q;
        endcase

        full_d = (ncommit_d == CNT_W'(NBUF));
        ovf_d  = ovf_q || (sel_s && (wr || pktend) && full_q);
    end

    // Pointer, counter, length and flag registers.
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            fill_buf_q  <= '0;
            fill_cnt_q  <= '0;
            drain_buf_q <= '0;
            drain_idx_q <= '0;
            ncommit_q   <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NBUF; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            fill_buf_q  <= fill_buf_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_buf_q <= drain_buf_d;
            drain_idx_q <= drain_idx_d;
            ncommit_q   <= ncommit_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
        end
    end

    // Packet storage; contents are deliberately left unreset.
    always_ff @(posedge ifclk) begin
        if (wr_acc_s) begin
            mem_q[mem_addr(fill_buf_q, fill_cnt_q)] <= data;
        end
    end

    assign full = full_q;
    assign ovf  = ovf_q;

`ifdef FX2_IN_EP_PF_EN
    localparam int OCC_W = $clog2(DEPTH + PKT_WORDS + 1) + 1;

    logic [OCC_W-1:0] occ_s;
    logic             pf_q, pf_d;

    // Occupancy after the edge: pending packet lengths, less what the host
    // already took from the head, plus the partially filled buffer.
    always_comb begin
        occ_s = '0;
        for (int i = 0; i < NBUF; i++) begin
            if (i < int'(ncommit_d)) begin
                occ_s = occ_s + OCC_W'(len_d[BUF_W'((int'(drain_buf_d) + i) % NBUF)]);
            end else begin
                occ_s = occ_s;
            end
        end
        occ_s = occ_s - OCC_W'(drain_idx_d) + OCC_W'(fill_cnt_d);
        pf_d  = (int'(occ_s) >= PF_LEVEL);
    end

    // Programmable-flag register.
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            pf_q <= 1'b0;
        end else begin
            pf_q <= pf_d;
        end
    end

    assign pf = pf_q;
`else
    logic unused_pf_level_s;

    assign unused_pf_level_s = (PF_LEVEL > 0);
    assign pf                = 1'b0;
`endif

endmodule

// File: doc/fx2_in_ep.md
# fx2_in_ep

Parametrised FX2 IN (device->host) endpoint FIFO model with multi-buffering, automatic packet commit, short-packet/ZLP handling and overflow detection. Sits on the FX2 slave-FIFO bus as the device-facing sink for one endpoint address. Exposes a host-side drain port so the bench can consume whole packets the way the USB host would. Successor to the single-byte, never-full IN model: the new block has real `full` back-pressure and packet boundaries.

## Interface
- FIFOADR, 2'b00, endpoint address this instance responds to
- DATA_W, 8, bus word width (8 or 16)
- PKT_WORDS, 512, words per packet buffer (auto-commit size)
- NBUF, 2, number of packet buffers (1, 2 or 4)
- PF_LEVEL, 256, programmable-flag threshold in words (used only with FX2_IN_EP_PF_EN)
- LEN_W, derived $clog2(PKT_WORDS+1), packet-length width

- ifclk  in  1  interface clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifoadr  in  2  FIFO address from device logic
- data  in  DATA_W  write data
- wr  in  1  write strobe, active high
- pktend  in  1  commit current packet, active high
- full  out  1  all NBUF buffers committed and undrained
- pf  out  1  programmable occupancy flag
- ovf  out  1  sticky: write or pktend attempted while full
- host_rd  in  1  host consumes one word (or one ZLP)
- host_valid  out  1  at least one committed packet pending
- host_data  out  DATA_W  current word of head packet
- host_len  out  LEN_W  length of head packet in words (0 = ZLP)
- host_last  out  1  current word/ZLP is last of head packet

## Operation
- Selected = (fifoadr == FIFOADR). Unselected wr/pktend ignored entirely.
- State: fill_buf, fill_cnt, drain_buf, drain_idx, ncommit (0..NBUF), per-buffer length registers.
- Write accepted when selected && wr && !full: store at [fill_buf][fill_cnt], fill_cnt++.
- Auto-commit: accepted write with fill_cnt == PKT_WORDS-1 commits buffer with length PKT_WORDS; fill_buf advances modulo NBUF, fill_cnt = 0.
- pktend (selected, !full): commits with length fill_cnt (0 gives a ZLP).
- wr and pktend same cycle: word included, length fill_cnt+1; if that write also auto-commits, exactly one commit, no trailing ZLP.
- wr or pktend while full: dropped, ovf set to 1 (held until reset).
- full = (ncommit == NBUF).
- host_valid = (ncommit != 0); host_data = buffer[drain_buf][drain_idx]; host_len = length[drain_buf].
- host_last = host_valid && (host_len == 0 || drain_idx == host_len-1).
- host_rd && host_valid: drain_idx++; if host_last, release: drain_buf advances modulo NBUF, drain_idx = 0, ncommit--. host_rd without host_valid ignored.
- Commit and release in same cycle: ncommit unchanged.
- Buffer contents not reset; all counters, pointers and flags are.

## Timing
- Reset (reset_n low, asynchronous): full 0, pf 0, ovf 0, host_valid 0, host_last 0, host_len 0; host_data don't-care.
- Accepted write and commit take effect at the ifclk edge; host_valid/host_len/full reflect it the following cycle (one-cycle latency).
- host_data, host_len, host_last are combinational from registered state; valid same cycle as host_valid.
- full deasserts the cycle after the release edge; a write presented in that cycle is accepted.
- Reset mid-packet discards partial and committed packets; next write lands at word 0 of buffer 0.

## Configuration
- FX2_IN_EP_PF_EN defined: pf is registered, 1 when (committed words + fill_cnt) >= PF_LEVEL after the edge, where committed words is the sum of all pending packet lengths minus drain_idx.
- Not defined: pf tied to 0; no occupancy arithmetic synthesised; port list unchanged.

## Test plan
- NBUF=2, PKT_WORDS=4: write 01,02,03,04 -> next cycle host_valid=1, host_len=4; four host_rd return 01..04, host_last only on 04, then host_valid=0.
- Write 8 words with no host_rd -> full=1 after 8th edge; 9th write ignored, ovf=1, draining still yields 8 original words.
- Write AA,BB then pktend -> host_len=2; then pktend alone -> ZLP host_len=0, host_last=1, one host_rd releases it.
- wr with 4th word and pktend same cycle -> exactly one packet of length 4, no ZLP follows (host_valid=0 after drain).
- ncommit=1, host_rd on head's last word same edge as auto-committing 4th write -> ncommit stays 1, full=0, new packet becomes head.
- Two writes then reset_n low for 1 cycle -> host_valid=0, full=0, ovf=0; next 4 writes 11..14 drain as 11..14.
